way_hit_select: RTL and testbench

- Tag-match and way-select datapath for a WAYS-way set-associative cache.
- Per way: equality-compares the stored tag against the lookup tag and ANDs the result with the way's valid bit. The one-hot hit vector then selects the way's line through an AND-OR mux.
- Results are registered: one-cycle lookup latency.
- Sits between the set's tag/data array read and the cache controller's hit/miss logic.

---
 rtl/way_hit_select_pkg.sv | 21 ++
 rtl/way_hit_select_if.sv | 31 +++
 rtl/way_hit_select_onehot_and_or_mux.sv | 19 +
 rtl/way_hit_select.sv | 99 +++++++++
 tb/tb_way_hit_select.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/way_hit_select_pkg.sv
// Shared cache constants and helpers for the tag-match / way-select datapath.
package cache_pkg;

    localparam int DEF_WAYS      = 4;
    localparam int DEF_TAG_BITS  = 18;
    localparam int DEF_LINE_BITS = 512;
    localparam int WAY_IDX_BITS  = $clog2(DEF_WAYS);

    // Upper bound on supported ways; callers zero-extend narrower vectors.
    localparam int MAX_WAYS = 64;

    function automatic logic [6:0] count_ones(input logic [MAX_WAYS-1:0] v);
        logic [6:0] n;
        n = 7'd0;
        for (int i = 0; i < MAX_WAYS; i++) begin
            n = n + {6'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/way_hit_select_if.sv
// Lookup request / result bundle between the set array read and the hit/miss logic.
interface way_hit_select_if import cache_pkg::*; #(
    parameter int WAYS      = DEF_WAYS,
    parameter int TAG_BITS  = DEF_TAG_BITS,
    parameter int LINE_BITS = DEF_LINE_BITS
) ();
    localparam int IDX_BITS = $clog2(WAYS);

    logic                      i_req;
    logic [TAG_BITS-1:0]       i_tag;
    logic [WAYS*TAG_BITS-1:0]  i_way_tags;
    logic [WAYS-1:0]           i_way_valid;
    logic [WAYS*LINE_BITS-1:0] i_way_data;

    logic                      o_valid;
    logic                      o_hit;
    logic [WAYS-1:0]           o_hit_vec;
    logic [IDX_BITS-1:0]       o_way_index;
    logic [LINE_BITS-1:0]      o_data;
    logic                      o_multi_hit;

    modport master (
        output i_req, i_tag, i_way_tags, i_way_valid, i_way_data,
        input  o_valid, o_hit, o_hit_vec, o_way_index, o_data, o_multi_hit
    );

    modport slave (
        input  i_req, i_tag, i_way_tags, i_way_valid, i_way_data,
        output o_valid, o_hit, o_hit_vec, o_way_index, o_data, o_multi_hit
    );
endinterface

// File: rtl/way_hit_select_onehot_and_or_mux.sv
// Combinational AND-OR line selector; several active selects OR their lines together.
module onehot_and_or_mux #(
    parameter int WAYS      = 4,
    parameter int LINE_BITS = 512
) (
    input  logic [WAYS*LINE_BITS-1:0] data_i,
    input  logic [WAYS-1:0]           sel_i,
    output logic [LINE_BITS-1:0]      data_o
);

    // Gate each line by its select bit and merge.
    always_comb begin
        data_o = '0;
        for (int w = 0; w < WAYS; w++) begin
            data_o = data_o | (data_i[w*LINE_BITS +: LINE_BITS] & {LINE_BITS{sel_i[w]}});
        end
    end

endmodule

// File: rtl/way_hit_select.sv
// Tag compare, valid gating and way select with a single registered result stage.
module way_hit_select import cache_pkg::*; #(
    parameter int WAYS      = DEF_WAYS,
    parameter int TAG_BITS  = DEF_TAG_BITS,
    parameter int LINE_BITS = DEF_LINE_BITS
) (
    input  logic            clk,
    input  logic            rst,
    way_hit_select_if.slave bus
);
    localparam int IDX_BITS = $clog2(WAYS);

    logic [WAYS-1:0]      match_s;
    logic [LINE_BITS-1:0] sel_data_s;
    logic                 multi_s;

    logic                 valid_d,     valid_q;
    logic                 hit_d,       hit_q;
    logic [WAYS-1:0]      hit_vec_d,   hit_vec_q;
    logic [IDX_BITS-1:0]  way_index_d, way_index_q;
    logic [LINE_BITS-1:0] data_d,      data_q;
    logic                 multi_hit_d, multi_hit_q;

    // An invalid way never hits, even on an exact tag match.
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign match_s[w] = (bus.i_way_tags[w*TAG_BITS +: TAG_BITS] == bus.i_tag)
                            & bus.i_way_valid[w];
    end

    onehot_and_or_mux #(
        .WAYS      (WAYS),
        .LINE_BITS (LINE_BITS)
    ) u_mux (
        .data_i (bus.i_way_data),
        .sel_i  (match_s),
        .data_o (sel_data_s)
    );

    function automatic logic [IDX_BITS-1:0] lowest_index(input logic [WAYS-1:0] v);
        logic [IDX_BITS-1:0] idx;
        idx = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (v[w]) begin
                idx = IDX_BITS'(w);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign multi_s = (count_ones(MAX_WAYS'(match_s)) > 7'd1);

    // Capture a new result on a request; otherwise hold everything but the strobe.
    always_comb begin
        if (bus.i_req) begin
            valid_d     = 1'b1;
            hit_d       = |match_s;
            hit_vec_d   = match_s;
            way_index_d = lowest_index(match_s);
            data_d      = sel_data_s;
            multi_hit_d = multi_s;
        end else begin
            valid_d     = 1'b0;
            hit_d       = hit_q;
            hit_vec_d   = hit_vec_q;
            way_index_d = way_index_q;
            data_d      = data_q;
            multi_hit_d = multi_hit_q;
        end
    end

    // Result register; reset wins over a same-cycle request.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            hit_q       <= 1'b0;
            hit_vec_q   <= '0;
            way_index_q <= '0;
            data_q      <= '0;
            multi_hit_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            hit_q       <= hit_d;
            hit_vec_q   <= hit_vec_d;
            way_index_q <= way_index_d;
            data_q      <= data_d;
            multi_hit_q <= multi_hit_d;
        end
    end

    assign bus.o_valid     = valid_q;
    assign bus.o_hit       = hit_q;
    assign bus.o_hit_vec   = hit_vec_q;
    assign bus.o_way_index = way_index_q;
    assign bus.o_data      = data_q;
    assign bus.o_multi_hit = multi_hit_q;

endmodule

// File: tb/tb_way_hit_select.sv
// Directed and randomized lookups checked against a behavioural cache-set model.
module tb_way_hit_select;
    import cache_pkg::*;

    localparam int W  = 4;
    localparam int TB = 18;
    localparam int LB = 512;
    localparam int IB = WAY_IDX_BITS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    way_hit_select_if #(.WAYS(W), .TAG_BITS(TB), .LINE_BITS(LB)) bus ();

    way_hit_select #(.WAYS(W), .TAG_BITS(TB), .LINE_BITS(LB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stimulus state, one entry per way.
    logic          req;
    logic [TB-1:0] tg;
    logic [TB-1:0] tags [W];
    logic [LB-1:0] lines [W];
    logic [W-1:0]  vld;

    // Expected outputs.
    logic          e_valid = 1'b0, e_hit = 1'b0, e_multi = 1'b0;
    logic [W-1:0]  e_hv = '0;
    logic [IB-1:0] e_idx = '0;
    logic [LB-1:0] e_data = '0;

    int compared = 0;
    int mismatched = 0;

    function automatic logic [LB-1:0] rand_line();
        logic [LB-1:0] r;
        for (int k = 0; k < LB / 32; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [TB-1:0] other_tag(input logic [TB-1:0] t);
        logic [TB-1:0] d;
        d = TB'($urandom_range(1, (1 << TB) - 1));
        return t ^ d;
    endfunction

    task automatic randomize_set();
        tg = TB'($urandom());
        for (int w = 0; w < W; w++) begin
            tags[w]  = other_tag(tg);
            lines[w] = rand_line();
        end
        vld = W'($urandom());
    endtask

    task automatic hit_only(input int k);
        randomize_set();
        tags[k] = tg;
        vld     = W'(1) << k;
    endtask

    task automatic apply();
        bus.i_req = req;
        bus.i_tag = tg;
        for (int w = 0; w < W; w++) begin
            bus.i_way_tags[w*TB +: TB] = tags[w];
            bus.i_way_data[w*LB +: LB] = lines[w];
        end
        bus.i_way_valid = vld;
    endtask

    // Reference: scan the ways as a cache set would, lowest hit wins the index.
    task automatic model();
        bit found;
        if (rst) begin
            e_valid = 1'b0; e_hit = 1'b0; e_multi = 1'b0;
            e_hv = '0; e_idx = '0; e_data = '0;
        end else if (req) begin
            found = 1'b0;
            e_hv = '0; e_idx = '0; e_data = '0;
            for (int w = 0; w < W; w++) begin
                if (vld[w] && tags[w] == tg) begin
                    e_hv[w] = 1'b1;
                    e_data  = e_data | lines[w];
                    if (!found) begin
                        e_idx = IB'(w);
                        found = 1'b1;
                    end
                end
            end
            e_valid = 1'b1;
            e_hit   = found;
            e_multi = ($countones(e_hv) > 1);
        end else begin
            e_valid = 1'b0;
        end
    endtask

    task automatic check(input string t);
        compared++;
        assert (bus.o_valid === e_valid) else begin
            mismatched++;
            $error("FAIL %s o_valid: observed %0b expected %0b", t, bus.o_valid, e_valid);
        end
        compared++;
        assert (bus.o_hit === e_hit) else begin
            mismatched++;
            $error("FAIL %s o_hit: observed %0b expected %0b", t, bus.o_hit, e_hit);
        end
        compared++;
        assert (bus.o_hit_vec === e_hv) else begin
            mismatched++;
            $error("FAIL %s o_hit_vec: observed %b expected %b", t, bus.o_hit_vec, e_hv);
        end
        compared++;
        assert (bus.o_way_index === e_idx) else begin
            mismatched++;
            $error("FAIL %s o_way_index: observed %0d expected %0d", t, bus.o_way_index, e_idx);
        end
        compared++;
        assert (bus.o_data === e_data) else begin
            mismatched++;
            $error("FAIL %s o_data: observed %h expected %h", t, bus.o_data, e_data);
        end
        compared++;
        assert (bus.o_multi_hit === e_multi) else begin
            mismatched++;
            $error("FAIL %s o_multi_hit: observed %0b expected %0b", t, bus.o_multi_hit, e_multi);
        end
    endtask

    task automatic cycle(input string t);
        apply();
        model();
        @(posedge clk);
        #1;
        check(t);
    endtask

    initial begin
        logic [W-1:0] vec_chk;
        logic [LB-1:0] line_chk;

        // Reset with random traffic and requests present.
        rst = 1'b1; req = 1'b1;
        randomize_set(); cycle("reset0");
        randomize_set(); cycle("reset1");
        rst = 1'b0;

        // Single hit on way 2.
        randomize_set();
        tg = 18'h2A5A5; tags[2] = 18'h2A5A5; vld = 4'b0100;
        lines[2] = {16{32'hDEADBEEF}};
        cycle("single_hit");
        compared++;
        assert (bus.o_way_index === 2'd2) else begin
            mismatched++;
            $error("FAIL single_hit_idx: observed %0d expected 2", bus.o_way_index);
        end

        // Matching tags on invalid ways only.
        randomize_set();
        for (int w = 0; w < W; w++) tags[w] = tg;
        vld = 4'b0000;
        cycle("invalid_match");

        // Two valid matches on ways 1 and 3.
        randomize_set();
        tags[1] = tg; tags[3] = tg; vld = 4'b1010;
        lines[1] = 512'h0F; lines[3] = 512'hF0;
        cycle("multi_hit");
        vec_chk = bus.o_hit_vec; line_chk = bus.o_data;
        compared++;
        assert (vec_chk === 4'b1010 && line_chk === 512'hFF && bus.o_multi_hit === 1'b1) else begin
            mismatched++;
            $error("FAIL multi_hit_const: observed vec=%b data=%h expected vec=1010 data=ff", vec_chk, line_chk);
        end

        // Back-to-back hits on ways 0, 3, 1, then idle.
        hit_only(0); cycle("pipe0");
        hit_only(3); cycle("pipe3");
        hit_only(1); cycle("pipe1");
        req = 1'b0; randomize_set(); cycle("hold");
        compared++;
        assert (bus.o_way_index === 2'd1 && bus.o_valid === 1'b0) else begin
            mismatched++;
            $error("FAIL hold_idx: observed idx=%0d valid=%0b expected idx=1 valid=0", bus.o_way_index, bus.o_valid);
        end

        // Reset together with a way-3 hit drops that request.
        req = 1'b1; hit_only(2); cycle("pre_rst");
        rst = 1'b1; hit_only(3); cycle("mid_rst");
        rst = 1'b0; req = 1'b0; randomize_set(); cycle("post_rst0");
        cycle("post_rst1");

        // Randomized traffic, biased toward tag matches.
        for (int i = 0; i < 400; i++) begin
            randomize_set();
            for (int w = 0; w < W; w++) begin
                if ($urandom_range(0, 1) == 1) tags[w] = tg;
            end
            req = ($urandom_range(0, 9) < 8);
            rst = ($urandom_range(0, 39) == 0);
            cycle("random");
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
